// File: rtl/seg7_scan_scheduler.sv
// Four-digit multiplexed 7-segment scanner with shadow registers committed at frame end.
// Each digit slot closes with a blanking window so segment data never bleeds into the next digit.
module seg7_scan_scheduler #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       CLK_50MHz,
  input  logic       Res,
  input  logic       wr_req,
  input  logic [1:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic       wr_ack,
  input  logic       freeze,
  output logic [6:0] SEG,
  output logic [3:0] SEG_COM,
  output logic       frame_tick
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST_TICK = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SHOW_END  = CW'(SCAN_DIV - BLANK_CYC);

  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'd0:    pat = 7'b100_0000;
      5'd1:    pat = 7'b111_1001;
      5'd2:    pat = 7'b010_0100;
      5'd3:    pat = 7'b011_0000;
      5'd4:    pat = 7'b001_1001;
      5'd5:    pat = 7'b001_0010;
      5'd6:    pat = 7'b000_0010;
      5'd7:    pat = 7'b101_1000;
      5'd8:    pat = 7'b000_0000;
      5'd9:    pat = 7'b001_1000;
      5'd10:   pat = 7'b000_1000;
      5'd11:   pat = 7'b000_0011;
      5'd12:   pat = 7'b100_0110;
      5'd13:   pat = 7'b010_0001;
      5'd14:   pat = 7'b000_0110;
      5'd15:   pat = 7'b000_1110;
      5'd16:   pat = 7'b011_1111;
      default: pat = 7'b111_1111;
    endcase
    return pat;
  endfunction

  logic [CW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    shadow_q [4];
  logic [4:0]    shadow_d [4];
  logic [4:0]    active_q [4];
  logic [4:0]    active_d [4];
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    seg_com_q, seg_com_d;
  logic          wr_ack_q, wr_ack_d;
  logic          frame_tick_q, frame_tick_d;

  logic          last_tick_s;
  logic          frame_end_s;
  logic          accept_s;
  logic          show_s;

  // Scan position, frame-end commit and write acceptance.
  always_comb begin
    last_tick_s  = (tick_q == LAST_TICK);
    frame_end_s  = last_tick_s && (idx_q == 2'd3);
    accept_s     = wr_req && !wr_ack_q;
    show_s       = (tick_q < SHOW_END);

    tick_d       = tick_q + CW'(1);
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    wr_ack_d     = accept_s;
    frame_tick_d = frame_end_s;

    if (last_tick_s) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      idx_d  = idx_q;
    end

    // Commit reads shadow_q, so a write landing on the same edge waits for the next frame.
    if (frame_end_s && !freeze) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end

    if (accept_s) begin
      shadow_d[wr_addr] = wr_data;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Output stage: derived from the current scan state, presented one cycle later.
  always_comb begin
    seg_d     = 7'b111_1111;
    seg_com_d = 4'b0000;
    if (show_s) begin
      seg_com_d = 4'b0001 << idx_q;
      seg_d     = seg_decode(active_q[idx_q]);
    end else begin
      seg_com_d = 4'b0000;
      seg_d     = 7'b111_1111;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_50MHz or negedge Res) begin
    if (!Res) begin
      tick_q       <= '0;
      idx_q        <= 2'd0;
      seg_q        <= 7'b111_1111;
      seg_com_q    <= 4'b0000;
      wr_ack_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= 5'd0;
        active_q[i] <= 5'd0;
      end
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      seg_com_q    <= seg_com_d;
      wr_ack_q     <= wr_ack_d;
      frame_tick_q <= frame_tick_d;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign SEG        = seg_q;
  assign SEG_COM    = seg_com_q;
  assign wr_ack     = wr_ack_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Bench for seg7_scan_scheduler: a frame-arithmetic reference model queues the expected
// outputs every cycle; an independent monitor pops and compares them against the DUT.
module tb_seg7_scan_scheduler;

  localparam int SD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = 4 * SD;

  localparam logic [6:0] DEC [17] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001,
    7'b001_0010, 7'b000_0010, 7'b101_1000, 7'b000_0000, 7'b001_1000,
    7'b000_1000, 7'b000_0011, 7'b100_0110, 7'b010_0001, 7'b000_0110,
    7'b000_1110, 7'b011_1111
  };

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] com;
    logic       ack;
    logic       tick;
  } exp_t;

  logic       clk;
  logic       res_n;
  logic       wr_req;
  logic [1:0] wr_addr;
  logic [4:0] wr_data;
  logic       wr_ack;
  logic       freeze;
  logic [6:0] seg;
  logic [3:0] seg_com;
  logic       frame_tick;

  int   errors;
  int   checks;
  exp_t exp_q[$];

  // reference model state: cycles since reset release and the two register banks
  int         mc;
  logic [4:0] sh_m  [4];
  logic [4:0] act_m [4];
  logic       ack_m;
  int         digit_m;
  int         slot_m;
  exp_t       e_m;
  exp_t       e_mon;

  seg7_scan_scheduler #(.SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
    .CLK_50MHz (clk),
    .Res       (res_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .freeze    (freeze),
    .SEG       (seg),
    .SEG_COM   (seg_com),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_decode(input logic [4:0] code);
    if (code <= 5'd16) return DEC[code];
    else return 7'b111_1111;
  endfunction

  // Reference model: one expected output set per clock edge.
  initial begin
    mc    = 0;
    ack_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sh_m[i]  = 5'd0;
      act_m[i] = 5'd0;
    end
    forever begin
      @(posedge clk);
      if (!res_n) begin
        e_m   = '{seg: 7'h7F, com: 4'd0, ack: 1'b0, tick: 1'b0};
        mc    = 0;
        ack_m = 1'b0;
        for (int i = 0; i < 4; i++) begin
          sh_m[i]  = 5'd0;
          act_m[i] = 5'd0;
        end
      end else begin
        slot_m  = mc % SD;
        digit_m = (mc / SD) % 4;
        if (slot_m < SD - BL) begin
          e_m.com = 4'(1 << digit_m);
          e_m.seg = ref_decode(act_m[digit_m]);
        end else begin
          e_m.com = 4'd0;
          e_m.seg = 7'h7F;
        end
        e_m.tick = ((mc % FRAME) == FRAME - 1);
        e_m.ack  = wr_req && !ack_m;
        if (e_m.tick && !freeze) act_m = sh_m;
        if (e_m.ack) sh_m[wr_addr] = wr_data;
        ack_m = e_m.ack;
        mc    = mc + 1;
      end
      exp_q.push_back(e_m);
    end
  end

  // Monitor: compares the DUT outputs after every edge against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
      end else begin
        e_mon = exp_q.pop_front();
        if (seg !== e_mon.seg || seg_com !== e_mon.com || wr_ack !== e_mon.ack ||
            frame_tick !== e_mon.tick) begin
          errors++;
          $display("FAIL scan t=%0t got seg=%b com=%b ack=%b tick=%b want seg=%b com=%b ack=%b tick=%b",
                   $time, seg, seg_com, wr_ack, frame_tick,
                   e_mon.seg, e_mon.com, e_mon.ack, e_mon.tick);
        end
      end
      checks++;
      if ($countones(seg_com) > 1) begin
        errors++;
        $display("FAIL com_onehot t=%0t got com=%b want at most one bit", $time, seg_com);
      end
    end
  end

  task automatic wait_slot(input int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ((mc % FRAME) == p) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_slot timeout got mc=%0d want slot %0d", mc, p);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [4:0] d);
    bit got;
    got     = 1'b0;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_ack) begin
        got = 1'b1;
        break;
      end
    end
    wr_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL write_ack addr=%0d got no ack want ack within 10 cycles", a);
    end
  endtask

  // Stimulus: directed scenarios, then randomized writes and freeze, then mid-frame reset.
  initial begin
    int n_ack;
    errors  = 0;
    checks  = 0;
    res_n   = 1'b0;
    wr_req  = 1'b0;
    wr_addr = 2'd0;
    wr_data = 5'd0;
    freeze  = 1'b0;
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    wait_slot(10);
    do_write(2'd2, 5'd7);
    repeat (2 * FRAME) @(negedge clk);

    wait_slot(5);
    wr_addr = 2'd1;
    wr_req  = 1'b1;
    n_ack   = 0;
    for (int i = 0; i < 6; i++) begin
      wr_data = 5'($urandom_range(0, 31));
      @(negedge clk);
      if (wr_ack) n_ack++;
    end
    wr_req = 1'b0;
    checks++;
    if (n_ack != 3) begin
      errors++;
      $display("FAIL held_req_accepts got %0d want 3", n_ack);
    end
    repeat (4) @(negedge clk);

    wait_slot(FRAME - 1);
    do_write(2'd0, 5'd16);
    repeat (2 * FRAME + 3) @(negedge clk);

    do_write(2'd3, 5'd20);
    wait_slot(20);
    freeze = 1'b1;
    repeat (FRAME) @(negedge clk);
    freeze = 1'b0;
    repeat (FRAME + 8) @(negedge clk);

    for (int k = 0; k < 30; k++) begin
      freeze = ($urandom_range(0, 5) == 0);
      do_write(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    freeze = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    wait_slot(0);
    do_write(2'd1, 5'd5);
    do_write(2'd2, 5'd9);
    wait_slot(19);
    res_n = 1'b0;
    #1;
    checks++;
    if (seg_com !== 4'b0000 || seg !== 7'b111_1111 || wr_ack !== 1'b0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got seg=%b com=%b ack=%b tick=%b want seg=1111111 com=0000 ack=0 tick=0",
               seg, seg_com, wr_ack, frame_tick);
    end
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    repeat (2 * FRAME + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
